// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Producer side of the instruction-word interface feeding the decoder LUT.
//   Sequences the program counter, issues reads to synchronous program
//   memory (one-cycle read latency), holds returned words in a small FIFO
//   prefetch buffer, and presents the buffer head under valid/ready.
//   Supports branch redirect with flush, halt, and consumer back-pressure.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   prog_rd         program memory read strobe
//   prog_addr       program memory read address (0 when prog_rd=0)
//   prog_data       read data, valid the cycle after prog_rd
//   instr           buffer head word (0 when instr_valid=0)
//   OP_dk, OP_s     instr[15:8], instr[15:12]
//   instr_pc        address of instr (0 when instr_valid=0)
//   instr_valid     buffer head holds a valid instruction
//   instr_ready     consumer accepts the head this cycle
//   branch_en       redirect fetch to branch_target, flushing everything
//   branch_target   redirect address
//   halt            suppress new reads
//   buf_count       registered buffer occupancy
module instruction_fetch #(
  parameter int                  PC_WIDTH = 12,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int                  DEPTH    = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         prog_rd,
  output logic [PC_WIDTH-1:0]          prog_addr,
  input  logic [15:0]                  prog_data,
  output logic [15:0]                  instr,
  output logic [7:0]                   OP_dk,
  output logic [3:0]                   OP_s,
  output logic [PC_WIDTH-1:0]          instr_pc,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  input  logic                         branch_en,
  input  logic [PC_WIDTH-1:0]          branch_target,
  input  logic                         halt,
  output logic [$clog2(DEPTH+1)-1:0]   buf_count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  // Fetch state
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                inflight_q, inflight_d;
  logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;

  // Prefetch FIFO (circular, DEPTH need not be a power of two)
  logic [DEPTH-1:0][15:0]         buf_data_q, buf_data_d;
  logic [DEPTH-1:0][PC_WIDTH-1:0] buf_pc_q, buf_pc_d;
  logic [PW-1:0]                  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]                  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]                  count_q, count_d;

  logic          pop;
  logic          push;
  logic [CW:0]   occupancy;
  logic [CW:0]   limit;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake and issue
  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid & instr_ready;
  // A branch kills the response arriving this cycle.
  assign push        = inflight_q & ~branch_en;

  // Issue only if the buffer plus the outstanding read still leaves a slot
  // after this cycle's pop; compared as count+inflight < DEPTH+pop to stay
  // unsigned.
  assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign limit     = DEPTH_W + {{CW{1'b0}}, pop};
  assign prog_rd   = ~reset & ~halt & ~branch_en & (occupancy < limit);
  assign prog_addr = prog_rd ? fetch_pc_q : '0;

  // Head presentation, zeroed when empty
  assign instr     = instr_valid ? buf_data_q[rd_ptr_q] : 16'h0;
  assign instr_pc  = instr_valid ? buf_pc_q[rd_ptr_q]   : '0;
  assign OP_dk     = instr[15:8];
  assign OP_s      = instr[15:12];
  assign buf_count = count_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = prog_rd;
    inflight_pc_d = inflight_pc_q;
    buf_data_d    = buf_data_q;
    buf_pc_d      = buf_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q + CW'(push) - CW'(pop);

    if (prog_rd) begin
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + PC_WIDTH'(1);
    end

    if (push) begin
      buf_data_d[wr_ptr_q] = prog_data;
      buf_pc_d[wr_ptr_q]   = inflight_pc_q;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    // Redirect: the pop above is already counted as consumed; everything
    // left in the buffer and the outstanding read are discarded.
    if (branch_en) begin
      fetch_pc_d = branch_target;
      inflight_d = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      buf_data_q    <= '0;
      buf_pc_q      <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      buf_data_q    <= buf_data_d;
      buf_pc_q      <= buf_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        prog_rd;
  logic [11:0] prog_addr;
  logic [15:0] prog_data = 16'h0;
  logic [15:0] instr;
  logic [7:0]  OP_dk;
  logic [3:0]  OP_s;
  logic [11:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        branch_en = 1'b0;
  logic [11:0] branch_target = 12'h0;
  logic        halt = 1'b0;
  logic [1:0]  buf_count;

  int n_checks = 0;
  int n_pass   = 0;

  instruction_fetch #(.PC_WIDTH(12), .RESET_PC(12'h000), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .prog_rd(prog_rd), .prog_addr(prog_addr),
    .prog_data(prog_data), .instr(instr), .OP_dk(OP_dk), .OP_s(OP_s),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_en(branch_en), .branch_target(branch_target), .halt(halt),
    .buf_count(buf_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [11:0] a);
    return 16'h1000 + {4'h0, a};
  endfunction

  // Synchronous program memory
  always @(posedge clk) prog_data <= prog_rd ? mem_word(prog_addr) : 16'hDEAD;

  logic [55:0] obs;
  assign obs = {prog_rd, prog_addr, instr_valid, instr, instr_pc, buf_count, OP_dk, OP_s};

  // Reference model: the buffer is a queue of fetched addresses, plus one
  // outstanding read slot.
  logic [11:0] m_q[$];
  bit          m_inf = 1'b0;
  logic [11:0] m_ipc = 12'h0;
  logic [11:0] m_fpc = 12'h0;

  function automatic logic [55:0] model_out();
    logic v, rd;
    logic [11:0] pc, addr;
    logic [15:0] w;
    logic [1:0] cnt;
    int occ;
    v    = (m_q.size() != 0);
    pc   = v ? m_q[0] : 12'h0;
    w    = v ? mem_word(pc) : 16'h0;
    occ  = m_q.size() + int'(m_inf) - int'(v && instr_ready);
    rd   = !reset && !halt && !branch_en && (occ < DEPTH);
    addr = rd ? m_fpc : 12'h0;
    cnt  = 2'(m_q.size());
    return {rd, addr, v, w, pc, cnt, w[15:8], w[15:12]};
  endfunction

  // Advance the model with the current inputs, then move to the next cycle.
  task automatic next_cycle();
    bit v, rd;
    int occ;
    v   = (m_q.size() != 0);
    occ = m_q.size() + int'(m_inf) - int'(v && instr_ready);
    rd  = !reset && !halt && !branch_en && (occ < DEPTH);
    if (reset) begin
      m_q.delete();
      m_inf = 1'b0;
      m_fpc = 12'h000;
    end else begin
      if (v && instr_ready) void'(m_q.pop_front());
      if (branch_en) begin
        m_q.delete();
        m_inf = 1'b0;
        m_fpc = branch_target;
      end else begin
        if (m_inf) m_q.push_back(m_ipc);
        m_inf = rd;
        if (rd) begin
          m_ipc = m_fpc;
          m_fpc = m_fpc + 12'h1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; halt = 1'b0; branch_en = 1'b0; instr_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      next_cycle();
    end
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; halt = 1'b0; branch_en = 1'b0; instr_ready = 1'b0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (obs !== 56'h0) $display("FAIL reset_outputs: got %h expected 0", obs);
    else n_pass++;
    next_cycle();
    instr_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== 56'h0) $display("FAIL reset_ready_held: got %h expected 0", obs);
    else n_pass++;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    instr_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== model_out()) $display("FAIL stream_model cyc=%0d: got %h expected %h", cyc, obs, model_out());
      else n_pass++;
      n_checks++;
      if (!(prog_rd === 1'b1 && prog_addr === 12'(cyc)))
        $display("FAIL stream_addr cyc=%0d: got rd=%b addr=%h expected rd=1 addr=%h", cyc, prog_rd, prog_addr, 12'(cyc));
      else n_pass++;
      n_checks++;
      if (cyc < 2) begin
        if (instr_valid !== 1'b0) $display("FAIL stream_latency cyc=%0d: got valid=%b expected 0", cyc, instr_valid);
        else n_pass++;
      end else begin
        if (!(instr_valid === 1'b1 && instr === 16'(16'h1000 + cyc - 2) && instr_pc === 12'(cyc - 2)))
          $display("FAIL stream_word cyc=%0d: got v=%b instr=%h pc=%h expected v=1 instr=%h pc=%h",
                   cyc, instr_valid, instr, instr_pc, 16'(16'h1000 + cyc - 2), 12'(cyc - 2));
        else n_pass++;
      end
      if (cyc == 2) begin
        n_checks++;
        if (!(OP_dk === 8'h10 && OP_s === 4'h1))
          $display("FAIL stream_opfields: got OP_dk=%h OP_s=%h expected 10 1", OP_dk, OP_s);
        else n_pass++;
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] got[$];
    do_reset();
    for (int cyc = 0; cyc < 20; cyc++) begin
      instr_ready = (cyc >= 8);
      @(negedge clk);
      n_checks++;
      if (obs !== model_out()) $display("FAIL bp_model cyc=%0d: got %h expected %h", cyc, obs, model_out());
      else n_pass++;
      if (cyc == 7) begin
        n_checks++;
        if (!(buf_count === 2'd2 && prog_rd === 1'b0))
          $display("FAIL bp_full: got count=%0d rd=%b expected count=2 rd=0", buf_count, prog_rd);
        else n_pass++;
      end
      if (instr_valid === 1'b1 && instr_ready) got.push_back(instr);
      next_cycle();
    end
    n_checks++;
    if (got.size() < 3) $display("FAIL bp_drain_count: got %0d words expected at least 3", got.size());
    else n_pass++;
    foreach (got[i]) begin
      n_checks++;
      if (got[i] !== 16'(16'h1000 + i)) $display("FAIL bp_order idx=%0d: got %h expected %h", i, got[i], 16'(16'h1000 + i));
      else n_pass++;
    end
  endtask

  task automatic test_branch();
    do_reset();
    instr_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      branch_en = (cyc == 5);
      branch_target = 12'h080;
      @(negedge clk);
      n_checks++;
      if (obs !== model_out()) $display("FAIL branch_model cyc=%0d: got %h expected %h", cyc, obs, model_out());
      else n_pass++;
      if (cyc == 5) begin
        n_checks++;
        if (!(instr_valid === 1'b1 && instr_pc === 12'h003 && prog_rd === 1'b0))
          $display("FAIL branch_pop: got v=%b pc=%h rd=%b expected v=1 pc=003 rd=0", instr_valid, instr_pc, prog_rd);
        else n_pass++;
      end
      if (cyc == 6) begin
        n_checks++;
        if (!(prog_rd === 1'b1 && prog_addr === 12'h080 && instr_valid === 1'b0))
          $display("FAIL branch_issue: got rd=%b addr=%h v=%b expected rd=1 addr=080 v=0", prog_rd, prog_addr, instr_valid);
        else n_pass++;
      end
      if (cyc == 7) begin
        n_checks++;
        if (instr_valid !== 1'b0) $display("FAIL branch_bubble: got v=%b expected 0", instr_valid);
        else n_pass++;
      end
      if (cyc == 8) begin
        n_checks++;
        if (!(instr_valid === 1'b1 && instr_pc === 12'h080 && instr === 16'h1080))
          $display("FAIL branch_target: got v=%b pc=%h instr=%h expected v=1 pc=080 instr=1080", instr_valid, instr_pc, instr);
        else n_pass++;
      end
      next_cycle();
    end
    branch_en = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    instr_ready = 1'b1;
    for (int cyc = 0; cyc < 11; cyc++) begin
      branch_en = (cyc == 3);
      branch_target = 12'hFFE;
      @(negedge clk);
      n_checks++;
      if (obs !== model_out()) $display("FAIL wrap_model cyc=%0d: got %h expected %h", cyc, obs, model_out());
      else n_pass++;
      if (cyc >= 6 && cyc <= 9) begin
        n_checks++;
        if (!(instr_valid === 1'b1 && instr_pc === 12'(12'hFFE + cyc - 6)))
          $display("FAIL wrap_pc cyc=%0d: got v=%b pc=%h expected v=1 pc=%h", cyc, instr_valid, instr_pc, 12'(12'hFFE + cyc - 6));
        else n_pass++;
      end
      next_cycle();
    end
    branch_en = 1'b0;
  endtask

  task automatic test_halt();
    logic [11:0] got[$];
    do_reset();
    instr_ready = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      halt = (cyc >= 5 && cyc <= 8);
      @(negedge clk);
      n_checks++;
      if (obs !== model_out()) $display("FAIL halt_model cyc=%0d: got %h expected %h", cyc, obs, model_out());
      else n_pass++;
      if (halt) begin
        n_checks++;
        if (prog_rd !== 1'b0) $display("FAIL halt_no_read cyc=%0d: got rd=%b expected 0", cyc, prog_rd);
        else n_pass++;
      end
      if (cyc == 6) begin
        n_checks++;
        if (!(instr_valid === 1'b1 && instr_pc === 12'h004))
          $display("FAIL halt_inflight: got v=%b pc=%h expected v=1 pc=004", instr_valid, instr_pc);
        else n_pass++;
      end
      if (instr_valid === 1'b1) got.push_back(instr_pc);
      next_cycle();
    end
    halt = 1'b0;
    foreach (got[i]) begin
      n_checks++;
      if (got[i] !== 12'(i)) $display("FAIL halt_sequence idx=%0d: got %h expected %h", i, got[i], 12'(i));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    for (int s = 0; s < 2; s++) begin
      do_reset();
      for (int cyc = 0; cyc < 11; cyc++) begin
        reset = (cyc == 4);
        instr_ready = (s == 1) ? 1'b1 : (cyc >= 5);
        @(negedge clk);
        n_checks++;
        if (obs !== model_out()) $display("FAIL rstmid_model s=%0d cyc=%0d: got %h expected %h", s, cyc, obs, model_out());
        else n_pass++;
        if (cyc == 4 && s == 0) begin
          n_checks++;
          if (buf_count !== 2'd2) $display("FAIL rstmid_full: got count=%0d expected 2", buf_count);
          else n_pass++;
        end
        if (cyc == 5) begin
          n_checks++;
          if (!(instr_valid === 1'b0 && buf_count === 2'd0 && prog_rd === 1'b1 && prog_addr === 12'h000))
            $display("FAIL rstmid_cleared s=%0d: got v=%b count=%0d rd=%b addr=%h expected 0 0 1 000",
                     s, instr_valid, buf_count, prog_rd, prog_addr);
          else n_pass++;
        end
        if (cyc == 6) begin
          n_checks++;
          if (instr_valid !== 1'b0) $display("FAIL rstmid_stale s=%0d: got v=%b pc=%h expected v=0", s, instr_valid, instr_pc);
          else n_pass++;
        end
        if (cyc == 7) begin
          n_checks++;
          if (!(instr_valid === 1'b1 && instr_pc === 12'h000 && instr === 16'h1000))
            $display("FAIL rstmid_restart s=%0d: got v=%b pc=%h instr=%h expected v=1 pc=000 instr=1000",
                     s, instr_valid, instr_pc, instr);
          else n_pass++;
        end
        next_cycle();
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      reset         = ($urandom_range(0, 63) == 0);
      instr_ready   = ($urandom_range(0, 3) != 0);
      halt          = ($urandom_range(0, 7) == 0);
      branch_en     = ($urandom_range(0, 15) == 0);
      branch_target = 12'($urandom);
      @(negedge clk);
      n_checks++;
      if (obs !== model_out()) $display("FAIL random_model cyc=%0d: got %h expected %h", cyc, obs, model_out());
      else n_pass++;
      next_cycle();
    end
    reset = 1'b0; halt = 1'b0; branch_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_branch();
    test_wrap();
    test_halt();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Producer end of the instruction-word interface consumed by the instruction decoder LUT. It sequences the program counter and issues reads to synchronous program memory. Returned words are held in a small prefetch buffer and presented to the decoder as a 16-bit instruction plus the OP_dk / OP_s opcode fields, under a valid/ready handshake. It handles sequential fetch (PC+1), branch redirect with flush, halt, and back-pressure from the execute stage.

Parameters:
PC_WIDTH, 12, program counter and program address width
RESET_PC, 0, first fetch address after reset
DEPTH, 2, prefetch buffer entries (legal 2..4)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
prog_rd  output  1  program memory read strobe
prog_addr  output  PC_WIDTH  program memory read address
prog_data  input  16  read data; valid the cycle after prog_rd
instr  output  16  instruction word at buffer head
OP_dk  output  8  instr[15:8]
OP_s  output  4  instr[15:12]
instr_pc  output  PC_WIDTH  address of instr
instr_valid  output  1  buffer head holds a valid instruction
instr_ready  input  1  consumer accepts head this cycle
branch_en  input  1  redirect fetch to branch_target
branch_target  input  PC_WIDTH  redirect address
halt  input  1  suppress new reads
buf_count  output  $clog2(DEPTH+1)  occupied buffer entries

Behaviour:
- Reset is synchronous and active-high. With reset=1 at a clock edge: fetch_pc=RESET_PC, buffer empty, in-flight flag=0, and all outputs 0 (prog_rd, prog_addr, instr, OP_dk, OP_s, instr_pc, instr_valid, buf_count).
- Reset asserted mid-operation discards buffer contents and any in-flight read; the response that arrives the next cycle is ignored.
- OP_dk and OP_s are combinational slices of instr. instr, OP_dk, OP_s and instr_pc are 0 when instr_valid=0.
- pop = instr_valid & instr_ready.
- Issue condition: prog_rd = !reset & !halt & !branch_en & (buf_count + inflight - pop < DEPTH).
- When prog_rd is asserted: prog_addr=fetch_pc; fetch_pc <= fetch_pc+1, wrapping from 2^PC_WIDTH-1 to 0; the in-flight PC tag is latched.
- Latency: read issued in cycle T → prog_data sampled at the end of T+1 → instr_valid=1 in T+2.
- After reset deasserts: the first prog_rd occurs in cycle 0 with addr RESET_PC, and the first instr_valid occurs in cycle 2.
- Sustained throughput is 1 instruction/cycle with instr_ready held 1.
- Buffer is FIFO order. Push and pop in the same cycle are both honoured; buf_count is unchanged.
- The buffer never overflows, because the issue condition reserves a slot for the in-flight read.
- Pop while empty: not possible, since instr_valid=0.
- Branch (branch_en=1 in cycle N):
  - A pop in cycle N is honoured first; then the whole buffer is flushed and the in-flight response is killed (not written in N+1).
  - fetch_pc <= branch_target. In N+1: instr_valid=0, and prog_rd=1 with addr=branch_target if halt=0.
  - Target instruction valid in N+3.
  - Back-to-back branches: the latest target wins, and each one flushes again.
- Halt:
  - No new reads. An in-flight read still completes into the buffer, and the buffer keeps draining normally.
  - Deasserting halt resumes reading at fetch_pc.
  - A branch taken during halt still flushes and updates fetch_pc; its read waits for halt=0.
- buf_count reflects the registered buffer occupancy.

Test Plan:
- Reset then stream, mem[i]=16'h1000+i, instr_ready=1: prog_addr 0,1,2... from cycle 0; instr_valid=1 from cycle 2; instr=16'h1000 with instr_pc=0, then one word per cycle; OP_dk=8'h10, OP_s=4'h1.
- Back-pressure: instr_ready=0 from cycle 2 for 6 cycles, DEPTH=2: buf_count reaches 2 and prog_rd deasserts. On release, words appear in order 16'h1000, 16'h1001, 16'h1002 with none lost or duplicated.
- Branch with read in flight: branch_en=1, branch_target=12'h080 at cycle 5 with instr_ready=1: the instr_pc=3 word is consumed in cycle 5 and the words at addresses 4 and 5 are dropped. prog_addr=12'h080 in cycle 6; instr_valid=0 in cycles 6-7; instr_pc=12'h080 valid in cycle 8.
- Wrap: branch to 12'hFFE with ready=1: instr_pc sequence FFE, FFF, 000, 001.
- Halt: assert halt for 4 cycles during streaming: prog_rd=0 during halt; the in-flight word is still delivered; fetch resumes at the next sequential address with no gap in instr_pc.
- Reset mid-stream: pulse reset with buf_count=2: next cycle instr_valid=0 and buf_count=0; fetch restarts at RESET_PC; the stale in-flight data is never presented.
